mc51_mem_resp: RTL and testbench

Memory-side responder for the mc51 core bus. It answers the core's active-low strobes: psen_n/rd_n for code fetch, rd_n for data read and we_n for data write. It inserts programmable wait states and returns a one-cycle o_data_rdy pulse with read data. It contains a code RAM, with a loader port for image preload, and an external-data RAM. It sits between the core control unit and on-chip memory and is the target end of the strobe/ready handshake the core initiates.

---
 rtl/mc51_bus_pkg.sv | 20 ++
 rtl/mc51_sync_ram.sv | 31 +++
 rtl/mc51_mem_resp.sv | 194 +++++++++++++++++++
 tb/tb_mc51_mem_resp.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc51_bus_pkg.sv
// Shared types and constants for the mc51 memory responder: FSM encoding,
// access kinds, out-of-range read value and wait-state counter width.
package mc51_bus_pkg;

    localparam int WS_W = 4;

    localparam logic [7:0] OOR_DATA = 8'hFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    typedef enum logic [1:0] {
        KIND_CODE_RD,
        KIND_DATA_RD,
        KIND_DATA_WR,
        KIND_ILLEGAL
    } access_kind_e;

endpackage

// File: rtl/mc51_sync_ram.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
// The read register updates on every enabled access, including writes.
module mc51_sync_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // NOTE: the array has no reset; contents survive reset_n and start undefined.
    always_ff @(posedge clk) begin
        if (en) begin
            // NOTE: non-blocking assignments make the read sample the pre-write byte.
            rdata_q <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mc51_mem_resp.sv
// Memory-side responder for the mc51 core bus: decodes strobes, inserts wait
// states, and returns a one-cycle ready pulse with code or data RAM read data.
module mc51_mem_resp
    import mc51_bus_pkg::*;
#(
    parameter int CODE_AW = 12,
    parameter int DATA_AW = 10,
    parameter int CODE_WS = 1,
    parameter int DATA_WS = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        i_mem_addr,
    input  logic [7:0]         i_mem_wdata,
    input  logic               i_psen_n,
    input  logic               i_rd_n,
    input  logic               i_we_n,
    output logic [7:0]         o_mem_rdata,
    output logic               o_data_rdy,
    output logic               o_busy,
    output logic               o_bus_err,
    input  logic               i_ld_we,
    input  logic [CODE_AW-1:0] i_ld_addr,
    input  logic [7:0]         i_ld_wdata
);

    logic [1:0]         state_q, state_d;
    logic [WS_W-1:0]    cnt_q, cnt_d;
    access_kind_e       kind_q, kind_d;
    logic [CODE_AW-1:0] addr_q, addr_d;
    logic               pend_q, pend_d;
    logic               oor_q, oor_d;
    logic               issued_q, issued_d;
    logic [7:0]         cap_q, cap_d;
    logic [7:0]         rdata_q, rdata_d;

    logic               bus_req;
    access_kind_e       bus_kind;
    logic               code_oor, data_oor;
    logic               code_rd_want, code_rd_go;
    logic [CODE_AW-1:0] code_rd_addr;
    logic               code_en, code_we;
    logic [CODE_AW-1:0] code_addr;
    logic               data_en, data_we;
    logic [7:0]         code_rdata, data_rdata, ram_sel, ack_data;

    always_comb begin
        bus_req = !(i_psen_n && i_rd_n && i_we_n);
        case ({i_psen_n, i_rd_n, i_we_n})
            3'b001:  bus_kind = KIND_CODE_RD;
            3'b101:  bus_kind = KIND_DATA_RD;
            3'b110:  bus_kind = KIND_DATA_WR;
            default: bus_kind = KIND_ILLEGAL;
        endcase
    end

    assign code_oor = |i_mem_addr[15:CODE_AW];
    assign data_oor = |i_mem_addr[15:DATA_AW];

    // Loader owns the code port; a core read only rides along when it targets
    // the same byte (read-first returns the old value), otherwise it waits.
    assign code_rd_want = (state_q == ST_IDLE && bus_kind == KIND_CODE_RD && !code_oor)
                       || (state_q == ST_WAIT && pend_q);
    assign code_rd_addr = (state_q == ST_IDLE) ? i_mem_addr[CODE_AW-1:0] : addr_q;
    assign code_rd_go   = code_rd_want && (!i_ld_we || i_ld_addr == code_rd_addr);
    assign code_en      = i_ld_we || code_rd_want;
    assign code_we      = i_ld_we;
    assign code_addr    = i_ld_we ? i_ld_addr : code_rd_addr;

    assign data_en = state_q == ST_IDLE && !data_oor
                  && (bus_kind == KIND_DATA_RD || bus_kind == KIND_DATA_WR);
    assign data_we = bus_kind == KIND_DATA_WR;

    mc51_sync_ram #(.AW(CODE_AW), .DW(8)) u_code_ram (
        .clk   (clk),
        .en    (code_en),
        .we    (code_we),
        .addr  (code_addr),
        .wdata (i_ld_wdata),
        .rdata (code_rdata)
    );

    mc51_sync_ram #(.AW(DATA_AW), .DW(8)) u_data_ram (
        .clk   (clk),
        .en    (data_en),
        .we    (data_we),
        .addr  (i_mem_addr[DATA_AW-1:0]),
        .wdata (i_mem_wdata),
        .rdata (data_rdata)
    );

    // RAM output is valid only the cycle after issue, so it is captured then.
    always_comb begin
        ram_sel  = (kind_q == KIND_CODE_RD) ? code_rdata : data_rdata;
        issued_d = code_rd_go || (data_en && !data_we);
        cap_d    = issued_q ? ram_sel : cap_q;
        if (kind_q == KIND_DATA_WR) begin
            ack_data = rdata_q;
        end else if (oor_q) begin
            ack_data = OOR_DATA;
        end else if (issued_q) begin
            ack_data = ram_sel;
        end else begin
            ack_data = cap_q;
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_req) begin
                    kind_d = bus_kind;
                    addr_d = i_mem_addr[CODE_AW-1:0];
                    pend_d = 1'b0;
                    case (bus_kind)
                        KIND_CODE_RD: begin
                            oor_d  = code_oor;
                            cnt_d  = WS_W'(CODE_WS);
                            pend_d = code_rd_want && !code_rd_go;
                        end
                        KIND_DATA_RD, KIND_DATA_WR: begin
                            oor_d = data_oor;
                            cnt_d = WS_W'(DATA_WS);
                        end
                        default: begin
                            oor_d = 1'b1;
                            cnt_d = '0;
                        end
                    endcase
                    state_d = (cnt_d != '0 || pend_d) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                // A deferred code read holds the count until it reaches the RAM.
                if (pend_q) begin
                    if (code_rd_go) begin
                        pend_d = 1'b0;
                        if (cnt_q == '0) begin
                            state_d = ST_ACK;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - WS_W'(1);
                    if (cnt_q <= WS_W'(1)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                rdata_d = ack_data;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            kind_q   <= KIND_CODE_RD;
            addr_q   <= '0;
            pend_q   <= 1'b0;
            oor_q    <= 1'b0;
            issued_q <= 1'b0;
            cap_q    <= 8'h00;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            pend_q   <= pend_d;
            oor_q    <= oor_d;
            issued_q <= issued_d;
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_data_rdy  = state_q == ST_ACK;
    assign o_busy      = state_q != ST_IDLE;
    assign o_bus_err   = state_q == ST_ACK && kind_q == KIND_ILLEGAL;
    assign o_mem_rdata = (state_q == ST_ACK) ? ack_data : rdata_q;

endmodule

// File: tb/tb_mc51_mem_resp.sv
// Self-checking bench for mc51_mem_resp: directed scenarios plus randomized
// traffic checked against a byte-array model of the code and data spaces.
module tb_mc51_mem_resp;

    localparam int CODE_AW = 12;
    localparam int DATA_AW = 10;
    localparam int CODE_WS = 1;
    localparam int DATA_WS = 2;

    localparam logic [2:0] P_CODE = 3'b001;
    localparam logic [2:0] P_DRD  = 3'b101;
    localparam logic [2:0] P_DWR  = 3'b110;

    typedef struct packed {
        logic [31:0] lat;
        logic [7:0]  data;
        logic        err;
    } resp_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [15:0]        i_mem_addr = '0;
    logic [7:0]         i_mem_wdata = '0;
    logic               i_psen_n = 1'b1;
    logic               i_rd_n = 1'b1;
    logic               i_we_n = 1'b1;
    logic [7:0]         o_mem_rdata;
    logic               o_data_rdy;
    logic               o_busy;
    logic               o_bus_err;
    logic               i_ld_we = 1'b0;
    logic [CODE_AW-1:0] i_ld_addr = '0;
    logic [7:0]         i_ld_wdata = '0;

    int checks = 0;
    int errors = 0;

    logic [7:0] code_m [int];
    logic [7:0] data_m [int];
    logic [7:0] last_rdata = 8'h00;

    always #5 clk = ~clk;

    mc51_mem_resp #(
        .CODE_AW(CODE_AW), .DATA_AW(DATA_AW), .CODE_WS(CODE_WS), .DATA_WS(DATA_WS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
        .i_psen_n(i_psen_n), .i_rd_n(i_rd_n), .i_we_n(i_we_n),
        .o_mem_rdata(o_mem_rdata), .o_data_rdy(o_data_rdy),
        .o_busy(o_busy), .o_bus_err(o_bus_err),
        .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr), .i_ld_wdata(i_ld_wdata)
    );

    // Expected response of one access, derived from the bus rules; updates the model.
    function automatic resp_t model(input logic [2:0] pat, input logic [15:0] addr,
                                    input logic [7:0] wd, input bit ld,
                                    input logic [CODE_AW-1:0] la, input logic [7:0] ldd);
        resp_t r;
        int a = int'(addr);
        r.err = 1'b0;
        case (pat)
            P_CODE: begin
                r.lat = CODE_WS + 1;
                if (a >= (1 << CODE_AW)) r.data = 8'hFF;
                else begin
                    r.data = code_m[a];
                    if (ld && int'(la) != a) r.lat = r.lat + 1;
                end
                last_rdata = r.data;
            end
            P_DRD: begin
                r.lat  = DATA_WS + 1;
                r.data = (a >= (1 << DATA_AW)) ? 8'hFF : data_m[a];
                last_rdata = r.data;
            end
            P_DWR: begin
                r.lat = DATA_WS + 1;
                if (a < (1 << DATA_AW)) data_m[a] = wd;
                r.data = last_rdata;
            end
            default: begin
                r.lat = 1;
                r.err = 1'b1;
                r.data = 8'hFF;
                last_rdata = 8'hFF;
            end
        endcase
        if (ld) code_m[int'(la)] = ldd;
        return r;
    endfunction

    // Drives one access and observes it; from_ack means the DUT is in its ACK cycle.
    task automatic access(input logic [2:0] pat, input logic [15:0] addr, input logic [7:0] wd,
                          input bit from_ack, input bit ld, input logic [CODE_AW-1:0] la,
                          input logic [7:0] ldd, output resp_t o, output int busy_cyc);
        bit got = 1'b0;
        {i_psen_n, i_rd_n, i_we_n} = pat;
        i_mem_addr  = addr;
        i_mem_wdata = wd;
        if (from_ack) begin
            @(posedge clk);
            #1;
        end
        i_ld_we = ld; i_ld_addr = la; i_ld_wdata = ldd;
        @(posedge clk);
        #1;
        i_ld_we = 1'b0;
        o = '0;
        busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            o.lat = o.lat + 1;
            if (o_busy) busy_cyc++;
            if (o_data_rdy) begin
                o.data = o_mem_rdata;
                o.err  = o_bus_err;
                got = 1'b1;
                break;
            end
        end
        if (!got) o.lat = '1;
        {i_psen_n, i_rd_n, i_we_n} = 3'b111;
    endtask

    task automatic step(input logic [2:0] pat, input logic [15:0] addr, input logic [7:0] wd,
                        input bit from_ack, input bit ld, input logic [CODE_AW-1:0] la,
                        input logic [7:0] ldd, output resp_t exp, output resp_t obs,
                        output int busy_cyc);
        exp = model(pat, addr, wd, ld, la, ldd);
        access(pat, addr, wd, from_ack, ld, la, ldd, obs, busy_cyc);
    endtask

    task automatic idle(input int n);
        {i_psen_n, i_rd_n, i_we_n} = 3'b111;
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [CODE_AW-1:0] a, input logic [7:0] d);
        i_ld_we = 1'b1; i_ld_addr = a; i_ld_wdata = d;
        @(posedge clk);
        #1;
        i_ld_we = 1'b0;
        code_m[int'(a)] = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({o_data_rdy, o_busy, o_bus_err, o_mem_rdata} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b busy=%b err=%b rdata=%h, want all 0",
                     o_data_rdy, o_busy, o_bus_err, o_mem_rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        checks++;
        if ({o_data_rdy, o_busy, o_bus_err, o_mem_rdata} !== 11'd0) begin
            errors++;
            $display("FAIL reset_idle: rdy=%b busy=%b err=%b rdata=%h, want all 0",
                     o_data_rdy, o_busy, o_bus_err, o_mem_rdata);
        end
    endtask

    task automatic test_code_read();
        resp_t exp, obs;
        int busy;
        load(12'h010, 8'hA5);
        step(P_CODE, 16'h0010, 8'h00, 1'b0, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp || busy != CODE_WS + 1) begin
            errors++;
            $display("FAIL code_read: lat=%0d data=%h err=%b busy=%0d, want lat=%0d data=%h err=%b busy=%0d",
                     obs.lat, obs.data, obs.err, busy, exp.lat, exp.data, exp.err, CODE_WS + 1);
        end
        @(negedge clk);
        checks++;
        if (o_data_rdy !== 1'b0 || o_busy !== 1'b0 || o_mem_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rdy_pulse: rdy=%b busy=%b rdata=%h, want 0 0 a5", o_data_rdy, o_busy, o_mem_rdata);
        end
    endtask

    task automatic test_back_to_back();
        resp_t exp, obs;
        int busy;
        step(P_DWR, 16'h0000, 8'h77, 1'b0, 1'b0, '0, 8'h00, exp, obs, busy);
        step(P_DWR, 16'h0033, 8'h5C, 1'b1, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL b2b_write: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                     obs.lat, obs.data, obs.err, exp.lat, exp.data, exp.err);
        end
        step(P_DRD, 16'h0033, 8'h00, 1'b1, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL b2b_read: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                     obs.lat, obs.data, obs.err, exp.lat, exp.data, exp.err);
        end
        idle(1);
    endtask

    task automatic test_out_of_range();
        resp_t exp, obs;
        int busy;
        step(P_CODE, 16'h1000, 8'h00, 1'b0, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL code_oor: lat=%0d data=%h, want lat=%0d data=%h", obs.lat, obs.data, exp.lat, exp.data);
        end
        step(P_DWR, 16'h0400, 8'h99, 1'b1, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL data_oor_wr: lat=%0d data=%h, want lat=%0d data=%h", obs.lat, obs.data, exp.lat, exp.data);
        end
        step(P_DRD, 16'h0000, 8'h00, 1'b1, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL data_oor_alias: data=%h, want %h", obs.data, exp.data);
        end
        step(P_DRD, 16'h8001, 8'h00, 1'b1, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL data_oor_rd: data=%h, want %h", obs.data, exp.data);
        end
        idle(1);
    endtask

    task automatic test_illegal();
        resp_t exp, obs;
        int busy;
        step(3'b100, 16'h0033, 8'h00, 1'b0, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL illegal: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b",
                     obs.lat, obs.data, obs.err, exp.lat, exp.data, exp.err);
        end
        @(negedge clk);
        checks++;
        if (o_bus_err !== 1'b0 || o_data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: err=%b rdy=%b, want 0 0", o_bus_err, o_data_rdy);
        end
        step(P_DRD, 16'h0033, 8'h00, 1'b0, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL illegal_no_write: data=%h, want %h", obs.data, exp.data);
        end
        idle(1);
    endtask

    task automatic test_loader_collision();
        resp_t exp, obs;
        int busy;
        step(P_CODE, 16'h0010, 8'h00, 1'b0, 1'b1, 12'h010, 8'h11, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ld_same_addr: lat=%0d data=%h, want lat=%0d data=%h", obs.lat, obs.data, exp.lat, exp.data);
        end
        step(P_CODE, 16'h0010, 8'h00, 1'b1, 1'b1, 12'h020, 8'h22, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ld_diff_addr: lat=%0d data=%h, want lat=%0d data=%h", obs.lat, obs.data, exp.lat, exp.data);
        end
        step(P_CODE, 16'h0020, 8'h00, 1'b1, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL ld_readback: data=%h, want %h", obs.data, exp.data);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_access();
        resp_t exp, obs;
        int busy;
        bit saw_rdy = 1'b0;
        exp = model(P_DWR, 16'h0005, 8'hC3, 1'b0, '0, 8'h00);
        {i_psen_n, i_rd_n, i_we_n} = P_DWR;
        i_mem_addr = 16'h0005; i_mem_wdata = 8'hC3;
        @(posedge clk);
        #1;
        {i_psen_n, i_rd_n, i_we_n} = 3'b111;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b, want 1", o_busy);
        end
        reset_n = 1'b0;
        #1;
        last_rdata = 8'h00;
        checks++;
        if ({o_data_rdy, o_busy, o_bus_err, o_mem_rdata} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_out: rdy=%b busy=%b err=%b rdata=%h, want all 0",
                     o_data_rdy, o_busy, o_bus_err, o_mem_rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_data_rdy || o_busy) saw_rdy = 1'b1;
        end
        checks++;
        if (saw_rdy) begin
            errors++;
            $display("FAIL mid_no_rdy: rdy/busy seen=1, want 0");
        end
        step(P_DRD, 16'h0005, 8'h00, 1'b0, 1'b0, '0, 8'h00, exp, obs, busy);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL mid_committed: data=%h, want %h", obs.data, exp.data);
        end
        idle(1);
    endtask

    task automatic test_random();
        resp_t exp, obs;
        int busy;
        bit b2b = 1'b0;
        logic [2:0] pat;
        logic [15:0] addr;
        logic [7:0] wd;
        bit ld;
        logic [CODE_AW-1:0] la;
        logic [2:0] illegal_pats [4] = '{3'b000, 3'b011, 3'b010, 3'b100};
        for (int i = 0; i < 64; i++) load(CODE_AW'(i), 8'($urandom));
        for (int i = 0; i < 64; i++) begin
            step(P_DWR, 16'(i), 8'($urandom), 1'b0, 1'b0, '0, 8'h00, exp, obs, busy);
            idle(1);
        end
        for (int i = 0; i < 200; i++) begin
            ld = 1'b0;
            la = '0;
            addr = 16'($urandom_range(0, 63));
            wd = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    pat = P_CODE;
                    if ($urandom_range(0, 9) == 0) addr = 16'h1000 | 16'($urandom);
                    if ($urandom_range(0, 2) == 0) begin
                        ld = 1'b1;
                        la = ($urandom_range(0, 2) == 0) ? addr[CODE_AW-1:0] : CODE_AW'($urandom_range(0, 63));
                    end
                end
                1: begin
                    pat = P_DRD;
                    if ($urandom_range(0, 9) == 0) addr = 16'h0400 | 16'($urandom);
                end
                2: begin
                    pat = P_DWR;
                    if ($urandom_range(0, 9) == 0) addr = 16'h0400 | 16'($urandom);
                end
                default: pat = illegal_pats[$urandom_range(0, 3)];
            endcase
            step(pat, addr, wd, b2b, ld, la, 8'($urandom), exp, obs, busy);
            checks++;
            if (obs !== exp || busy != int'(exp.lat)) begin
                errors++;
                $display("FAIL random[%0d] pat=%b addr=%h: lat=%0d data=%h err=%b busy=%0d, want lat=%0d data=%h err=%b",
                         i, pat, addr, obs.lat, obs.data, obs.err, busy, exp.lat, exp.data, exp.err);
            end
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) idle($urandom_range(1, 3));
        end
        if (b2b) idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_code_read();
        test_back_to_back();
        test_out_of_range();
        test_illegal();
        test_loader_collision();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
